// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are all zero.
module muldiv_unit #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  resetControl,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] operand_A,
   input  logic [DATA_WIDTH-1:0] operand_B,
   input  logic                  write_hi,
   input  logic                  write_lo,
   output logic [DATA_WIDTH-1:0] hi_out,
   output logic [DATA_WIDTH-1:0] lo_out,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero
);

   localparam int unsigned N  = DATA_WIDTH;
   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {StIdle, StCalc, StSignFix} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            is_div_q, is_div_d;
   logic            neg_q, neg_d;
   logic            rem_neg_q, rem_neg_d;
   logic [2*N-1:0]  mcand_q, mcand_d;
   logic [N-1:0]    mplier_q, mplier_d;
   logic [2*N-1:0]  acc_q, acc_d;
   logic [N-1:0]    quo_q, quo_d;
   logic [N-1:0]    rem_q, rem_d;
   logic [N-1:0]    hi_q, hi_d;
   logic [N-1:0]    lo_q, lo_d;
   logic            done_q, done_d;
   logic            dbz_q, dbz_d;

   logic            is_signed, sign_a, sign_b;
   logic [N-1:0]    abs_a, abs_b;
   logic [N:0]      rem_sh, rem_diff;
   logic [2*N-1:0]  mul_sum, prod_fixed;
   logic [N-1:0]    quo_fixed, rem_fixed;
   logic            last_iter;

   // Signed ops (op[0]==0) work on magnitudes; signs are re-applied in SIGN_FIX.
   assign is_signed = ~op[0];
   assign sign_a    = is_signed & operand_A[N-1];
   assign sign_b    = is_signed & operand_B[N-1];
   assign abs_a     = sign_a ? -operand_A : operand_A;
   assign abs_b     = sign_b ? -operand_B : operand_B;

   assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign rem_sh   = {rem_q, quo_q[N-1]};
   assign rem_diff = rem_sh - {1'b0, mplier_q};

   assign prod_fixed = neg_q     ? -acc_q : acc_q;
   assign quo_fixed  = neg_q     ? -quo_q : quo_q;
   assign rem_fixed  = rem_neg_q ? -rem_q : rem_q;

`ifdef MULDIV_EARLY_OUT_EN
   assign last_iter = (cnt_q == CW'(N - 1)) || (!is_div_q && (mplier_q[N-1:1] == '0));
`else
   assign last_iter = (cnt_q == CW'(N - 1));
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (op[1] && (operand_B == '0)) begin
                  // Divide by zero completes immediately and leaves HI/LO untouched.
                  done_d = 1'b1;
                  dbz_d  = 1'b1;
               end else begin
                  state_d   = StCalc;
                  cnt_d     = '0;
                  is_div_d  = op[1];
                  neg_d     = sign_a ^ sign_b;
                  rem_neg_d = sign_a;
                  mcand_d   = {{N{1'b0}}, abs_a};
                  mplier_d  = abs_b;
                  acc_d     = '0;
                  quo_d     = abs_a;
                  rem_d     = '0;
               end
            end else begin
               if (write_hi) hi_d = operand_A;
               if (write_lo) lo_d = operand_A;
            end
         end
         StCalc: begin
            if (is_div_q) begin
               // Quotient register shifts dividend bits out as quotient bits shift in.
               if (!rem_diff[N]) begin
                  rem_d = rem_diff[N-1:0];
                  quo_d = {quo_q[N-2:0], 1'b1};
               end else begin
                  rem_d = rem_sh[N-1:0];
                  quo_d = {quo_q[N-2:0], 1'b0};
               end
            end else begin
               acc_d    = mul_sum;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end
            cnt_d = cnt_q + CW'(1);
            if (last_iter) state_d = StSignFix;
         end
         StSignFix: begin
            if (is_div_q) begin
               lo_d = quo_fixed;
               hi_d = rem_fixed;
            end else begin
               hi_d = prod_fixed[2*N-1:N];
               lo_d = prod_fixed[N-1:0];
            end
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge resetControl) begin
      if (resetControl) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign hi_out      = hi_q;
   assign lo_out      = lo_q;
   assign busy        = (state_q != StIdle);
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors queued at launch, checked when done pulses.
module tb_muldiv_unit;

   localparam logic [1:0] OpMult  = 2'b00;
   localparam logic [1:0] OpMultu = 2'b01;
   localparam logic [1:0] OpDiv   = 2'b10;
   localparam logic [1:0] OpDivu  = 2'b11;

   logic        clock = 1'b0;
   logic        resetControl;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_A, operand_B;
   logic        write_hi, write_lo;
   logic [31:0] hi_out, lo_out;
   logic        busy, done, div_by_zero;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          lat;
      int          launch;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clock        (clock),
      .resetControl (resetControl),
      .start        (start),
      .op           (op),
      .operand_A    (operand_A),
      .operand_B    (operand_B),
      .write_hi     (write_hi),
      .write_lo     (write_lo),
      .hi_out       (hi_out),
      .lo_out       (lo_out),
      .busy         (busy),
      .done         (done),
      .div_by_zero  (div_by_zero)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Multiply latency model: n iterations then one SIGN_FIX edge.
   function automatic int mul_lat(input logic [31:0] b, input logic sgn);
      logic [31:0] m;
      int          n;
      m = (sgn && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`else
      n = 32;
`endif
      return n + 1;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(done), 64'(0));
         end else begin
            e = sb.pop_front();
            check("hi",          64'(hi_out),      64'(e.hi));
            check("lo",          64'(lo_out),      64'(e.lo));
            check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            check("latency",     64'(cyc - e.launch), 64'(e.lat));
            check("busy_at_done", 64'(busy),       64'(0));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the launch edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input int lat);
      exp_t e;
      start     = 1'b1;
      op        = o;
      operand_A = a;
      operand_B = b;
      e = '{hi: eh, lo: el, dbz: ed, lat: lat, launch: cyc + 1};
      sb.push_back(e);
      @(negedge clock);
      start     = 1'b0;
      op        = ~o;
      operand_A = 32'hDEAD_BEEF;
      operand_B = 32'h0000_0003;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
      check("drain_timeout", 64'(sb.size()), 64'(0));
      @(negedge clock);
   endtask

   task automatic mt(input logic wh, input logic wl, input logic [31:0] a);
      write_hi  = wh;
      write_lo  = wl;
      operand_A = a;
      @(negedge clock);
      write_hi  = 1'b0;
      write_lo  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int nbusy;
      resetControl = 1'b1;
      start = 1'b0; op = 2'b00; operand_A = '0; operand_B = '0;
      write_hi = 1'b0; write_lo = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_hi",   64'(hi_out), 64'(0));
      check("rst_lo",   64'(lo_out), 64'(0));
      check("rst_busy", 64'(busy),   64'(0));
      check("rst_done", 64'(done),   64'(0));
      check("rst_dbz",  64'(div_by_zero), 64'(0));
      resetControl = 1'b0;
      @(negedge clock);

      // Full-width MULTU with busy profile over cycles 0..33.
      issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
      nbusy = 0;
      for (int k = 0; k < 34; k++) begin
         if (busy) nbusy++;
         if (k == 33) check("busy_low_c33", 64'(busy), 64'(0));
         @(negedge clock);
      end
      check("busy_cycles", 64'(nbusy), 64'(33));
      wait_idle();

      issue(OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0,
            mul_lat(32'd5, 1'b1));
      wait_idle();
      issue(OpMult, 32'd5, 32'd3, 32'h0, 32'd15, 1'b0, mul_lat(32'd3, 1'b1));
      wait_idle();

      issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
      wait_idle();
      issue(OpDiv, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33);
      wait_idle();

      // MTLO while busy is dropped.
      issue(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
      mt(1'b0, 1'b1, 32'h0000_ABCD);
      check("mtlo_busy_ignored", 64'(lo_out), 64'hFFFF_FFFD);
      wait_idle();

      issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 33);
      wait_idle();

      // Divide by zero, then a back-to-back launch from the done cycle.
      mt(1'b1, 1'b0, 32'h11);
      mt(1'b0, 1'b1, 32'h22);
      issue(OpDivu, 32'd100, 32'd0, 32'h11, 32'h22, 1'b1, 0);
      check("dbz_busy_low", 64'(busy), 64'(0));
      issue(OpMultu, 32'd9, 32'd9, 32'h0, 32'd81, 1'b0, mul_lat(32'd9, 1'b0));
      wait_idle();

      // Asynchronous reset in the middle of CALC.
      issue(OpMultu, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 33);
      repeat (9) @(negedge clock);
      #2 resetControl = 1'b1;
      #1;
      check("amid_busy", 64'(busy),   64'(0));
      check("amid_done", 64'(done),   64'(0));
      check("amid_hi",   64'(hi_out), 64'(0));
      check("amid_lo",   64'(lo_out), 64'(0));
      sb.delete();
      @(negedge clock);
      resetControl = 1'b0;
      @(negedge clock);
      issue(OpMultu, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, mul_lat(32'd7, 1'b0));
      wait_idle();

      // MT writes in IDLE, simultaneous HI/LO write, and start beating write_hi.
      mt(1'b0, 1'b1, 32'h0000_ABCD);
      check("mtlo_idle", 64'(lo_out), 64'h0000_ABCD);
      mt(1'b1, 1'b1, 32'h77);
      check("mt_both_hi", 64'(hi_out), 64'h77);
      check("mt_both_lo", 64'(lo_out), 64'h77);
      mt(1'b1, 1'b0, 32'h5555);
      write_hi = 1'b1;
      issue(OpMultu, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, mul_lat(32'd3, 1'b0));
      write_hi = 1'b0;
      check("start_beats_mthi", 64'(hi_out), 64'h5555);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
